// File: rtl/line_pkg.sv
// Shared types and widths for the line endpoint animator and its per-axis bouncers.
package line_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned VEL_W   = COORD_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } anim_state_t;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [VEL_W-1:0]   vel_t;

endpackage

// File: rtl/axis_bouncer.sv
// One bouncing coordinate: position + signed velocity, reflect at 0/MAX, load with clamp.
module axis_bouncer
    import line_pkg::*;
#(
    parameter int unsigned MAX  = 639,
    parameter int unsigned STEP = 3,
    parameter int unsigned INIT = 2
) (
    input  logic   vga_clk,
    input  logic   rst_n,
    input  logic   commit,
    input  logic   use_load,
    input  logic   move,
    input  coord_t ld_val,
    output coord_t pos,
    output logic   changed_c
);

    localparam vel_t   MAX_V   = vel_t'(MAX);
    localparam vel_t   TWO_MAX = vel_t'(2 * MAX);
    localparam vel_t   STEP_V  = vel_t'(STEP);
    localparam coord_t MAX_C   = coord_t'(MAX);
    localparam coord_t INIT_C  = coord_t'(INIT);

    vel_t   vel;
    vel_t   vel_nxt_c;
    vel_t   sum_c;
    coord_t pos_nxt_c;

    // Shadow position/velocity for the next commit; load wins over motion.
    always_comb begin
        pos_nxt_c = pos;
        vel_nxt_c = vel;
        sum_c     = $signed({1'b0, pos}) + vel;
        if (use_load) begin
            pos_nxt_c = (ld_val > MAX_C) ? MAX_C : ld_val;
        end else if (move) begin
            if (sum_c > MAX_V) begin
                pos_nxt_c = coord_t'(TWO_MAX - sum_c);
                vel_nxt_c = -vel;
            end else if (sum_c[VEL_W-1]) begin
                pos_nxt_c = coord_t'(-sum_c);
                vel_nxt_c = -vel;
            end else begin
                pos_nxt_c = coord_t'(sum_c);
            end
        end
    end

    assign changed_c = (pos_nxt_c != pos);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= INIT_C;
            vel <= STEP_V;
        end else if (commit) begin
            pos <= pos_nxt_c;
            vel <= vel_nxt_c;
        end
    end

endmodule

// File: rtl/line_endpoint_animator.sv
// Animates the four line endpoints once per FRAME_DIV frames, synchronised to the Vsync leading edge,
// with a valid/ready port that overrides the endpoints at the next update.
module line_endpoint_animator
    import line_pkg::*;
#(
    parameter int unsigned H_MAX     = 639,
    parameter int unsigned V_MAX     = 479,
    parameter int unsigned FRAME_DIV = 2,
    parameter int unsigned STEP_X0   = 3,
    parameter int unsigned STEP_Y0   = 2,
    parameter int unsigned STEP_X1   = 1,
    parameter int unsigned STEP_Y1   = 4,
    parameter int unsigned INIT_X0   = 2,
    parameter int unsigned INIT_Y0   = 7,
    parameter int unsigned INIT_X1   = 9,
    parameter int unsigned INIT_Y1   = 2,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic               Vsync,
    input  logic               enable,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [COORD_W-1:0] ld_x0,
    input  logic [COORD_W-1:0] ld_y0,
    input  logic [COORD_W-1:0] ld_x1,
    input  logic [COORD_W-1:0] ld_y1,
    output logic [COORD_W-1:0] nx0,
    output logic [COORD_W-1:0] ny0,
    output logic [COORD_W-1:0] nx1,
    output logic [COORD_W-1:0] ny1,
    output logic               upd_pulse
);

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    anim_state_t      state;
    anim_state_t      state_nxt;
    logic             vs_q;
    logic             edge_c;
    logic             due_c;
    logic             due_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             commit_c;
    logic             move_c;
    logic             ld_xfer_c;
    logic             ld_pend;
    coord_t           pend_x0, pend_y0, pend_x1, pend_y1;
    logic [3:0]       chg_c;

    assign edge_c    = (Vsync == VSYNC_POL) && (vs_q != VSYNC_POL);
    assign due_c     = edge_c && (frame_cnt == CNT_W'(FRAME_DIV - 1));
    assign ld_xfer_c = ld_valid && ld_ready;
    assign move_c    = due_q && enable;

    // Vsync edge detect and frame divider; the counter advances on every edge, even mid-update.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= ~VSYNC_POL;
            frame_cnt <= '0;
        end else begin
            vs_q <= Vsync;
            if (edge_c) begin
                frame_cnt <= due_c ? '0 : frame_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Endpoints commit on the CALC->COMMIT edge so they are visible while in COMMIT.
    always_comb begin
        state_nxt = state;
        commit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (edge_c) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                commit_c  = 1'b1;
                state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load handshake, due latch and update strobe.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ready  <= 1'b1;
            ld_pend   <= 1'b0;
            pend_x0   <= '0;
            pend_y0   <= '0;
            pend_x1   <= '0;
            pend_y1   <= '0;
            due_q     <= 1'b0;
            upd_pulse <= 1'b0;
        end else begin
            upd_pulse <= commit_c && (|chg_c);
            if ((state == IDLE) && edge_c) begin
                due_q <= due_c;
            end
            if (ld_xfer_c) begin
                ld_pend <= 1'b1;
                pend_x0 <= ld_x0;
                pend_y0 <= ld_y0;
                pend_x1 <= ld_x1;
                pend_y1 <= ld_y1;
            end else if (state == COMMIT) begin
                ld_pend <= 1'b0;
            end
            if (((state == IDLE) && edge_c) || ld_xfer_c) begin
                ld_ready <= 1'b0;
            end else if (state == COMMIT) begin
                ld_ready <= 1'b1;
            end
        end
    end

    axis_bouncer #(.MAX(H_MAX), .STEP(STEP_X0), .INIT(INIT_X0)) u_x0 (
        .vga_clk(vga_clk), .rst_n(rst_n), .commit(commit_c), .use_load(ld_pend),
        .move(move_c), .ld_val(pend_x0), .pos(nx0), .changed_c(chg_c[0])
    );

    axis_bouncer #(.MAX(V_MAX), .STEP(STEP_Y0), .INIT(INIT_Y0)) u_y0 (
        .vga_clk(vga_clk), .rst_n(rst_n), .commit(commit_c), .use_load(ld_pend),
        .move(move_c), .ld_val(pend_y0), .pos(ny0), .changed_c(chg_c[1])
    );

    axis_bouncer #(.MAX(H_MAX), .STEP(STEP_X1), .INIT(INIT_X1)) u_x1 (
        .vga_clk(vga_clk), .rst_n(rst_n), .commit(commit_c), .use_load(ld_pend),
        .move(move_c), .ld_val(pend_x1), .pos(nx1), .changed_c(chg_c[2])
    );

    axis_bouncer #(.MAX(V_MAX), .STEP(STEP_Y1), .INIT(INIT_Y1)) u_y1 (
        .vga_clk(vga_clk), .rst_n(rst_n), .commit(commit_c), .use_load(ld_pend),
        .move(move_c), .ld_val(pend_y1), .pos(ny1), .changed_c(chg_c[3])
    );

endmodule

// File: tb/tb_line_endpoint_animator.sv
// Scoreboard bench: stimulus pushes expected endpoints, monitors pop them on each upd_pulse.
module tb_line_endpoint_animator;
    import line_pkg::*;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
    } pt_t;

    logic         vga_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         Vsync   = 1'b1;
    logic         Vsync2  = 1'b1;
    logic         enable  = 1'b1;
    logic         ld_valid = 1'b0;
    logic         ld_valid2 = 1'b0;
    coord_t       ld_x0 = '0, ld_y0 = '0, ld_x1 = '0, ld_y1 = '0;
    coord_t       zero_ld = '0;
    logic         ld_ready, ld_ready2;
    coord_t       nx0, ny0, nx1, ny1;
    coord_t       mx0, my0, mx1, my1;
    logic         upd_pulse, upd_pulse2;

    int  vectors    = 0;
    int  miscompares = 0;
    pt_t q1[$];
    pt_t q2[$];
    int  cur[4] = '{2, 7, 9, 2};

    always #5 vga_clk = ~vga_clk;

    line_endpoint_animator #(.FRAME_DIV(1)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .Vsync(Vsync), .enable(enable),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .nx0(nx0), .ny0(ny0), .nx1(nx1), .ny1(ny1), .upd_pulse(upd_pulse)
    );

    line_endpoint_animator #(.FRAME_DIV(2)) dut2 (
        .vga_clk(vga_clk), .rst_n(rst_n), .Vsync(Vsync2), .enable(enable),
        .ld_valid(ld_valid2), .ld_ready(ld_ready2),
        .ld_x0(zero_ld), .ld_y0(zero_ld), .ld_x1(zero_ld), .ld_y1(zero_ld),
        .nx0(mx0), .ny0(my0), .nx1(mx1), .ny1(my1), .upd_pulse(upd_pulse2)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cur(input string tag);
        chk({tag, "_nx0"}, int'(nx0), cur[0]);
        chk({tag, "_ny0"}, int'(ny0), cur[1]);
        chk({tag, "_nx1"}, int'(nx1), cur[2]);
        chk({tag, "_ny1"}, int'(ny1), cur[3]);
    endtask

    // Monitor for the FRAME_DIV=1 instance
    initial begin
        pt_t e;
        forever begin
            @(negedge vga_clk);
            if (upd_pulse) begin
                if (q1.size() == 0) begin
                    chk("dut_unexpected_upd", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("sb_nx0", int'(nx0), e.x0);
                    chk("sb_ny0", int'(ny0), e.y0);
                    chk("sb_nx1", int'(nx1), e.x1);
                    chk("sb_ny1", int'(ny1), e.y1);
                end
            end
        end
    end

    // Monitor for the FRAME_DIV=2 instance
    initial begin
        pt_t e;
        forever begin
            @(negedge vga_clk);
            if (upd_pulse2) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_upd", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("sb2_nx0", int'(mx0), e.x0);
                    chk("sb2_ny0", int'(my0), e.y0);
                    chk("sb2_nx1", int'(mx1), e.x1);
                    chk("sb2_ny1", int'(my1), e.y1);
                end
            end
        end
    end

    // One Vsync pulse; checks hold at E and E+1, strobe at E+2, ld_ready back at E+3.
    task automatic vs_pulse(input bit exp_upd, input bit both,
                            input int e0, input int e1, input int e2, input int e3);
        pt_t e;
        e.x0 = e0; e.y0 = e1; e.x1 = e2; e.y1 = e3;
        if (exp_upd) q1.push_back(e);
        @(posedge vga_clk);
        #1 Vsync = 1'b0;
        if (both) Vsync2 = 1'b0;
        repeat (2) begin
            @(negedge vga_clk);
            chk("hold_upd", int'(upd_pulse), 0);
            chk_cur("hold");
        end
        @(negedge vga_clk);
        chk("upd_at_e2", int'(upd_pulse), int'(exp_upd));
        if (exp_upd) cur = '{e0, e1, e2, e3};
        @(posedge vga_clk);
        #1 Vsync = 1'b1;
        Vsync2 = 1'b1;
        @(negedge vga_clk);
        chk("ld_ready_e3", int'(ld_ready), 1);
        chk("upd_one_cycle", int'(upd_pulse), 0);
        repeat (4) @(negedge vga_clk);
        chk_cur("after");
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d);
        int n = 0;
        @(posedge vga_clk);
        #1 ld_valid = 1'b1;
        ld_x0 = 12'(a); ld_y0 = 12'(b); ld_x1 = 12'(c); ld_y1 = 12'(d);
        @(negedge vga_clk);
        while (!ld_ready && n < 20) begin
            @(negedge vga_clk);
            n++;
        end
        if (!ld_ready) chk("ld_timeout", 0, 1);
        @(posedge vga_clk);
        #1 ld_valid = 1'b0;
        @(negedge vga_clk);
        chk("ld_ready_drop", int'(ld_ready), 0);
        chk_cur("ld_hold");
        repeat (3) @(negedge vga_clk);
    endtask

    initial begin
        repeat (3) @(negedge vga_clk);
        chk_cur("reset");
        chk("reset_ld_ready", int'(ld_ready), 1);
        chk("reset_upd", int'(upd_pulse), 0);
        chk("reset2_nx0", int'(mx0), 2);
        @(posedge vga_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge vga_clk);

        // Free motion on both instances; FRAME_DIV=2 moves on pulses 2 and 4 only
        vs_pulse(1, 1, 5, 9, 10, 6);
        q2.push_back('{5, 9, 10, 6});
        vs_pulse(1, 1, 8, 11, 11, 10);
        vs_pulse(1, 1, 11, 13, 12, 14);
        q2.push_back('{8, 11, 11, 10});
        vs_pulse(1, 1, 14, 15, 13, 18);

        // Bounce off the far edge, clamp, and off zero
        do_load(638, 100, 50, 1);
        vs_pulse(1, 0, 638, 100, 50, 1);
        vs_pulse(1, 0, 637, 102, 51, 5);
        vs_pulse(1, 0, 634, 104, 52, 9);
        do_load(100, 200, 4000, 478);
        vs_pulse(1, 0, 100, 200, 639, 478);
        vs_pulse(1, 0, 97, 202, 638, 476);
        do_load(0, 0, 0, 1);
        vs_pulse(1, 0, 0, 0, 0, 1);
        vs_pulse(1, 0, 3, 2, 1, 3);
        vs_pulse(1, 0, 6, 4, 2, 7);

        // Handshake with mid-frame load
        do_load(100, 200, 300, 400);
        vs_pulse(1, 0, 100, 200, 300, 400);

        // Frozen motion, loads still apply
        enable = 1'b0;
        repeat (3) vs_pulse(0, 0, 0, 0, 0, 0);
        do_load(10, 20, 30, 40);
        vs_pulse(1, 0, 10, 20, 30, 40);
        vs_pulse(0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        vs_pulse(1, 0, 13, 22, 31, 44);

        // Reset during CALC abandons the update
        @(posedge vga_clk);
        #1 Vsync = 1'b0;
        @(posedge vga_clk);
        #1 rst_n = 1'b0;
        Vsync = 1'b1;
        @(negedge vga_clk);
        cur = '{2, 7, 9, 2};
        chk_cur("midrst");
        chk("midrst_ld_ready", int'(ld_ready), 1);
        chk("midrst_upd", int'(upd_pulse), 0);
        @(posedge vga_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        vs_pulse(1, 0, 5, 9, 10, 6);

        repeat (4) @(negedge vga_clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
